// File: rtl/grid_check_pkg.sv
// grid_check_pkg: shared definitions for the grid checker.
//   - GRID_ORDER / GRID_LENGTH / GRID_CELLS: default grid geometry
//     (block side, cells per row/col/block, total cells).
//   - fail_kind_e: first-failure classification reported by the checker.
//   - chk_state_e: checker FSM states.
package grid_check_pkg;

  localparam int GRID_ORDER  = 3;
  localparam int GRID_LENGTH = GRID_ORDER * GRID_ORDER;
  localparam int GRID_CELLS  = GRID_LENGTH * GRID_LENGTH;

  typedef enum logic [1:0] {
    FK_NONE        = 2'd0,
    FK_NOT_ONEHOT  = 2'd1,
    FK_DUPLICATE   = 2'd2,
    FK_SOURCE_FAIL = 2'd3
  } fail_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } chk_state_e;

endpackage

// File: rtl/grid_checker_masks.sv
// grid_check_masks: seen-value masks for the grid checker.
// Holds one running row mask, one mask per column and one per block, and
// flags the cell currently presented as not-one-hot or as a duplicate.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-low reset
//   clear_i       - clear every mask (new check accepted)
//   update_i      - cell on row_i/col_i/data_i is being evaluated this cycle
//   row_i, col_i  - coordinate of the evaluated cell
//   data_i        - one-hot cell value
//   not_onehot_o  - data_i is not exactly one-hot (zero included)
//   duplicate_o   - data_i overlaps the row, column or block mask
module grid_check_masks #(
  parameter  int ORDER  = 3,
  localparam int LENGTH = ORDER * ORDER,
  localparam int IDXW   = $clog2(LENGTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              update_i,
  input  logic [IDXW-1:0]   row_i,
  input  logic [IDXW-1:0]   col_i,
  input  logic [LENGTH-1:0] data_i,
  output logic              not_onehot_o,
  output logic              duplicate_o
);

  logic [LENGTH-1:0] row_mask_q;
  logic [LENGTH-1:0] col_mask_q [LENGTH];
  logic [LENGTH-1:0] blk_mask_q [LENGTH];

  logic [LENGTH-1:0] row_prev;
  logic [LENGTH-1:0] col_sel;
  logic [LENGTH-1:0] blk_sel;
  logic [IDXW-1:0]   blk_idx;

  always_comb begin
    blk_idx = IDXW'((int'(row_i) / ORDER) * ORDER + int'(col_i) / ORDER);
    // A new row starts at column 0: ignore the previous row's contents.
    row_prev = (col_i == '0) ? '0 : row_mask_q;
    col_sel  = '0;
    blk_sel  = '0;
    for (int k = 0; k < LENGTH; k++) begin
      if (col_i == IDXW'(k))   col_sel = col_mask_q[k];
      if (blk_idx == IDXW'(k)) blk_sel = blk_mask_q[k];
    end
    not_onehot_o = !$onehot(data_i);
    duplicate_o  = |(data_i & (row_prev | col_sel | blk_sel));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        row_mask_q <= '0;
    else if (clear_i)  row_mask_q <= '0;
    else if (update_i) row_mask_q <= row_prev | data_i;
  end

  for (genvar gi = 0; gi < LENGTH; gi++) begin : g_masks
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        col_mask_q[gi] <= '0;
        blk_mask_q[gi] <= '0;
      end else if (clear_i) begin
        col_mask_q[gi] <= '0;
        blk_mask_q[gi] <= '0;
      end else if (update_i) begin
        if (col_i == IDXW'(gi))   col_mask_q[gi] <= col_mask_q[gi] | data_i;
        if (blk_idx == IDXW'(gi)) blk_mask_q[gi] <= blk_mask_q[gi] | data_i;
      end
    end
  end

endmodule

// File: rtl/grid_checker.sv
// grid_checker: reads a finished grid one cell per cycle (row-major) over a
// synchronous read port and confirms every row, column and block is a
// permutation of 1..LENGTH. Reports pass/fail and the first offending cell.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-low reset
//   start, src_success    - begin check (IDLE only) / source success flag
//   rd_en, rd_row, rd_col - read strobe and address to the cell store
//   rd_data               - one-hot cell value, valid the cycle after rd_en
//   busy, done            - check in progress / one-cycle completion pulse
//   valid                 - grid passed (held until next accepted start)
//   fail_kind/row/col     - first failure kind and coordinate (held)
// Build option: define GRID_CHECKER_EARLY_ABORT_EN to finish on the first
// failure instead of always scanning the whole grid.
module grid_checker
  import grid_check_pkg::*;
#(
  parameter  int ORDER  = GRID_ORDER,
  localparam int LENGTH = ORDER * ORDER,
  localparam int IDXW   = $clog2(LENGTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              src_success,
  output logic              rd_en,
  output logic [IDXW-1:0]   rd_row,
  output logic [IDXW-1:0]   rd_col,
  input  logic [LENGTH-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [1:0]        fail_kind,
  output logic [IDXW-1:0]   fail_row,
  output logic [IDXW-1:0]   fail_col
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LENGTH - 1);

  chk_state_e      state_q;
  fail_kind_e      fail_kind_q, fail_kind_d, cell_kind;
  logic            rd_en_q, busy_q, done_q, valid_q;
  logic [IDXW-1:0] rd_row_q, rd_col_q, fail_row_q, fail_col_q;
  // Address of the cell whose data is on rd_data this cycle.
  logic            chk_valid_q;
  logic [IDXW-1:0] chk_row_q, chk_col_q;

  logic check_en, cell_fail, first_fail, last_addr, clear_masks;
  logic not_onehot, duplicate;

  always_comb begin
    check_en    = chk_valid_q && (state_q == ST_READ || state_q == ST_DRAIN);
    cell_fail   = check_en && (not_onehot || duplicate);
    cell_kind   = not_onehot ? FK_NOT_ONEHOT : FK_DUPLICATE;
    first_fail  = cell_fail && (fail_kind_q == FK_NONE);
    fail_kind_d = first_fail ? cell_kind : fail_kind_q;
    last_addr   = (rd_row_q == LAST_IDX) && (rd_col_q == LAST_IDX);
    clear_masks = (state_q == ST_IDLE) && start;
  end

  grid_check_masks #(.ORDER(ORDER)) u_masks (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (clear_masks),
    .update_i     (check_en),
    .row_i        (chk_row_q),
    .col_i        (chk_col_q),
    .data_i       (rd_data),
    .not_onehot_o (not_onehot),
    .duplicate_o  (duplicate)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      fail_kind_q <= FK_NONE;
      fail_row_q  <= '0;
      fail_col_q  <= '0;
      chk_valid_q <= 1'b0;
      chk_row_q   <= '0;
      chk_col_q   <= '0;
    end else begin
      chk_valid_q <= rd_en_q;
      chk_row_q   <= rd_row_q;
      chk_col_q   <= rd_col_q;

      if (first_fail) begin
        fail_kind_q <= cell_kind;
        fail_row_q  <= chk_row_q;
        fail_col_q  <= chk_col_q;
      end

      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            valid_q    <= 1'b0;
            fail_row_q <= '0;
            fail_col_q <= '0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            busy_q     <= 1'b1;
            if (src_success) begin
              state_q     <= ST_READ;
              rd_en_q     <= 1'b1;
              fail_kind_q <= FK_NONE;
            end else begin
              state_q     <= ST_FIN;
              fail_kind_q <= FK_SOURCE_FAIL;
            end
          end
        end

        ST_READ: begin
          if (last_addr) begin
            rd_en_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else if (rd_col_q == LAST_IDX) begin
            rd_col_q <= '0;
            rd_row_q <= rd_row_q + 1'b1;
          end else begin
            rd_col_q <= rd_col_q + 1'b1;
          end
`ifdef GRID_CHECKER_EARLY_ABORT_EN
          if (first_fail) begin
            state_q <= ST_FIN;
            rd_en_q <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
`endif
        end

        // Last cell is evaluated on this edge; finish with its verdict.
        ST_DRAIN: begin
          state_q <= ST_FIN;
          done_q  <= 1'b1;
          valid_q <= (fail_kind_d == FK_NONE);
          busy_q  <= 1'b0;
        end

        // Still busy here only on the source-fail path, whose done pulse
        // comes one edge after entry; otherwise done is already high.
        ST_FIN: begin
          if (busy_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_row    = rd_row_q;
  assign rd_col    = rd_col_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign valid     = valid_q;
  assign fail_kind = fail_kind_q;
  assign fail_row  = fail_row_q;
  assign fail_col  = fail_col_q;

endmodule
